mux_serializer_ctrl: RTL and testbench
======================================

Name: mux_serializer_ctrl

Overview:
Sequencer placed directly upstream of the 16:1 bit-select mux stage. It accepts a parallel word over a valid/ready handshake, presents the word on the mux data input, and steps the mux select through the requested bit positions, one per accepted beat. It returns the mux's single-bit output as a serial stream with valid/ready/last. A down-stream bit stream is produced without any local shift register; the mux performs the bit selection.

Parameters:
DATA_W, 16, word width presented to the mux; must equal 2**SEL_W
SEL_W, 4, width of the mux select and of the length field

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  parallel word valid
in_ready  output  1  controller can accept a word
in_data  input  DATA_W  word to serialise
in_len  input  SEL_W  number of bits to emit minus 1 (0 means 1 bit, 15 means 16 bits)
mux_in  output  DATA_W  registered word driven to the mux data input
mux_sel  output  SEL_W  registered select driven to the mux
mux_out  input  1  combinational bit returned by the mux
ser_valid  output  1  serial bit valid
ser_ready  input  1  downstream accepts the serial bit
ser_data  output  1  serial bit; equals mux_out directly, with no register
ser_last  output  1  final bit of the current word
busy  output  1  high while in SHIFT

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, mux_in=0, mux_sel=0, len_q=0.
  - Outputs: ser_valid=0, ser_last=0, busy=0, in_ready=1.
- FSM has two states: IDLE and SHIFT.
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid && in_ready: mux_in<=in_data, len_q<=in_len, mux_sel<=start index, state<=SHIFT.
- SHIFT:
  - ser_valid=1, busy=1.
  - ser_last=1 when mux_sel equals the end index.
  - Beat = ser_valid && ser_ready.
  - Non-last beat: mux_sel advances by one position toward the end index.
  - ser_ready=0: stall. mux_in, mux_sel, ser_valid and ser_last all hold.
  - Last beat: if in_valid=1 the same cycle, the next word is loaded and state stays SHIFT (zero-bubble back-to-back). Otherwise state<=IDLE.
- in_ready = (state==IDLE) || (state==SHIFT && ser_last && ser_ready). This is combinational from ser_ready by design.
- Default order is LSB-first: start index=0, end index=len_q, mux_sel increments.
- Latency:
  - First serial bit is valid in the cycle after word acceptance.
  - A word of in_len=N takes N+1 beats.
  - Throughput is 1 bit/cycle with ser_ready tied high, including across word boundaries.
- in_data and in_len are sampled only on acceptance. Changes while busy have no effect.
- mux_sel never exceeds 2**SEL_W-1; no wrap occurs because the end index is bounded by len_q.
- in_len=0: single beat, ser_last=1 on the first beat.
- Reset asserted mid-word: word is abandoned, outputs immediately take reset values, and no ser_last is emitted.

Optional Feature:
MUX_SERIALIZER_MSB_FIRST_EN
- Defined: start index=len_q, end index=0, mux_sel decrements. ser_last=1 when mux_sel==0. All handshake and latency rules are unchanged.
- Undefined: LSB-first as above.

Test Plan:
1. Reset release, then in_data=16'hA5C3, in_len=15, ser_ready=1 → 16 consecutive beats with mux_sel 0..15; ser_data 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; ser_last only on the 16th beat; then IDLE with in_ready=1.
2. in_len=0, in_data=16'h0001 → exactly one beat, ser_data=1, ser_last=1; busy high for 1 cycle.
3. Backpressure: in_data=16'hFFFF, in_len=3, ser_ready toggling 1,0,0,1,1,0,1 → exactly 4 beats. mux_sel holds on every ser_ready=0 cycle; ser_last on the 4th beat only.
4. Back-to-back: word0=16'h000F, len 3, then word1=16'h0000, len 1, with in_valid held and ser_ready=1 → 6 beats with no idle cycle: data 1,1,1,1,0,0; ser_last on beats 4 and 6; in_ready pulses in the cycle of beat 4.
5. rst asserted after 5 beats of a len-15 word → ser_valid=0, mux_sel=0, mux_in=0 asynchronously. After release the next word starts cleanly at mux_sel=0.
6. With MUX_SERIALIZER_MSB_FIRST_EN, in_data=16'h8001, in_len=15 → mux_sel 15..0, ser_data 1 then fourteen 0s then 1; ser_last at mux_sel=0.

Source files
------------

// File: rtl/mux_serializer_ctrl.sv
// rtl/mux_serializer_ctrl.sv - sequencer stepping a 16:1 bit-select mux to serialise a parallel word
//
// Purpose:
//   Accepts a parallel word over in_valid/in_ready.
//   Drives the word onto the mux data input and steps mux_sel through bit positions, one per beat.
//   Returns the mux's single-bit output as a serial stream with valid/ready/last.
//   No local shift register is used; the mux performs the bit selection.
//
// Optional build macro:
//   MUX_SERIALIZER_MSB_FIRST_EN  when defined, bits go out MSB-first (mux_sel counts len..0).
//                                When undefined, bits go out LSB-first (mux_sel counts 0..len).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   parallel word valid
//   in_ready   controller can accept a word (combinational from ser_ready on the last beat)
//   in_data    word to serialise
//   in_len     number of bits to emit minus 1
//   mux_in     registered word driven to the mux data input
//   mux_sel    registered select driven to the mux
//   mux_out    combinational bit returned by the mux
//   ser_valid  serial bit valid
//   ser_ready  downstream accepts the serial bit
//   ser_data   serial bit, passed straight through from mux_out
//   ser_last   final bit of the current word
//   busy       high while shifting
module mux_serializer_ctrl #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_len,
  output logic [DATA_W-1:0] mux_in,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_data,
  output logic              ser_last,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] len_q;
  logic [SEL_W-1:0] start_idx;
  logic [SEL_W-1:0] next_sel;
  logic             next_last;
  logic             accept;

`ifdef MUX_SERIALIZER_MSB_FIRST_EN
  // Count down from the top requested bit; the word ends at bit 0.
  assign start_idx = in_len;
  assign next_sel  = mux_sel - SEL_W'(1);
  assign next_last = (mux_sel == SEL_W'(1));
`else
  // Count up from bit 0; the word ends at the stored length.
  assign start_idx = '0;
  assign next_sel  = mux_sel + SEL_W'(1);
  assign next_last = (next_sel == len_q);
`endif

  // Accepting on the last beat lets the next word follow with no idle cycle.
  assign in_ready = (state == IDLE) || ((state == SHIFT) && ser_last && ser_ready);
  assign accept   = in_valid && in_ready;
  assign ser_data = mux_out;

  // ser_valid, ser_last and busy are flops.
  // ser_last is precomputed one step ahead so it is valid in the same cycle as the matching mux_sel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mux_in    <= '0;
      mux_sel   <= '0;
      len_q     <= '0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      state     <= SHIFT;
      mux_in    <= in_data;
      len_q     <= in_len;
      mux_sel   <= start_idx;
      ser_valid <= 1'b1;
      ser_last  <= (in_len == '0);
      busy      <= 1'b1;
    end else if ((state == SHIFT) && ser_ready) begin
      if (ser_last) begin
        state     <= IDLE;
        ser_valid <= 1'b0;
        ser_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        mux_sel  <= next_sel;
        ser_last <= next_last;
      end
    end
  end

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
// tb/tb_mux_serializer_ctrl.sv - directed self-checking bench for mux_serializer_ctrl
module tb_mux_serializer_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_len = '0;
  logic [15:0] mux_in;
  logic [3:0]  mux_sel;
  logic        mux_out;
  logic        ser_valid;
  logic        ser_ready = 1'b0;
  logic        ser_data;
  logic        ser_last;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural 16:1 mux downstream of the controller.
  assign mux_out = mux_in[mux_sel];

  mux_serializer_ctrl #(.DATA_W(16), .SEL_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
    .mux_in(mux_in), .mux_sel(mux_sel), .mux_out(mux_out),
    .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_data(ser_data),
    .ser_last(ser_last), .busy(busy)
  );

  task automatic test_reset();
    @(negedge clk); #1;
    n_cmp++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL reset_ser_valid got %b want 0", ser_valid); end
    n_cmp++; if (ser_last !== 1'b0) begin n_err++; $display("FAIL reset_ser_last got %b want 0", ser_last); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (mux_sel !== 4'd0) begin n_err++; $display("FAIL reset_mux_sel got %0d want 0", mux_sel); end
    n_cmp++; if (mux_in !== 16'h0000) begin n_err++; $display("FAIL reset_mux_in got %h want 0000", mux_in); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    #1;
    n_cmp++; if (ser_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_idle got valid=%b busy=%b in_ready=%b want 0 0 1", tag, ser_valid, busy, in_ready);
    end
  endtask

  task automatic test_lsb_full();
    logic exp_bit [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hA5C3; in_len = 4'd15; ser_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_accept_ready got %b want 1", in_ready); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b0; in_data = 16'h1234; in_len = 4'd2;
      #1;
      n_cmp++; if (ser_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL full_valid beat %0d got valid=%b busy=%b want 1 1", i, ser_valid, busy); end
      n_cmp++; if (mux_sel !== 4'(i)) begin n_err++; $display("FAIL full_sel beat %0d got %0d want %0d", i, mux_sel, i); end
      n_cmp++; if (ser_data !== exp_bit[i]) begin n_err++; $display("FAIL full_data beat %0d got %b want %b", i, ser_data, exp_bit[i]); end
      n_cmp++; if (ser_last !== (i == 15)) begin n_err++; $display("FAIL full_last beat %0d got %b want %b", i, ser_last, (i == 15)); end
    end
    @(negedge clk);
    check_idle("full");
  endtask

  task automatic test_single_bit();
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0001; in_len = 4'd0; ser_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (ser_valid !== 1'b1 || ser_data !== 1'b1 || ser_last !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL single_beat got valid=%b data=%b last=%b busy=%b want 1 1 1 1", ser_valid, ser_data, ser_last, busy);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    check_idle("single");
  endtask

  task automatic test_backpressure();
    logic       rdy      [7] = '{1,0,0,1,1,0,1};
    logic [3:0] exp_sel  [7] = '{0,1,1,1,2,3,3};
    logic       exp_last [7] = '{0,0,0,0,0,1,1};
    int beats = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hFFFF; in_len = 4'd3; ser_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      in_valid = 1'b0; ser_ready = rdy[c];
      #1;
      n_cmp++; if (ser_valid !== 1'b1 || ser_data !== 1'b1) begin n_err++; $display("FAIL bp_valid cycle %0d got valid=%b data=%b want 1 1", c, ser_valid, ser_data); end
      n_cmp++; if (mux_sel !== exp_sel[c]) begin n_err++; $display("FAIL bp_sel cycle %0d got %0d want %0d", c, mux_sel, exp_sel[c]); end
      n_cmp++; if (ser_last !== exp_last[c]) begin n_err++; $display("FAIL bp_last cycle %0d got %b want %b", c, ser_last, exp_last[c]); end
      if (ser_valid && ser_ready) beats++;
    end
    n_cmp++; if (beats != 4) begin n_err++; $display("FAIL bp_beats got %0d want 4", beats); end
    @(negedge clk);
    ser_ready = 1'b1;
    check_idle("bp");
  endtask

  task automatic test_back_to_back();
    logic exp_data [6] = '{1,1,1,1,0,0};
    logic exp_last [6] = '{0,0,0,1,0,1};
    logic exp_rdy  [6] = '{0,0,0,1,0,1};
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h000F; in_len = 4'd3; ser_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      in_data = 16'h0000; in_len = 4'd1;
      if (b >= 4) in_valid = 1'b0;
      #1;
      n_cmp++; if (ser_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid beat %0d got %b want 1", b + 1, ser_valid); end
      n_cmp++; if (ser_data !== exp_data[b]) begin n_err++; $display("FAIL b2b_data beat %0d got %b want %b", b + 1, ser_data, exp_data[b]); end
      n_cmp++; if (ser_last !== exp_last[b]) begin n_err++; $display("FAIL b2b_last beat %0d got %b want %b", b + 1, ser_last, exp_last[b]); end
      n_cmp++; if (in_ready !== exp_rdy[b]) begin n_err++; $display("FAIL b2b_in_ready beat %0d got %b want %b", b + 1, in_ready, exp_rdy[b]); end
    end
    @(negedge clk);
    check_idle("b2b");
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hFFFF; in_len = 4'd15; ser_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #1;
    n_cmp++; if (mux_sel !== 4'd4 || ser_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre got sel=%0d valid=%b want 4 1", mux_sel, ser_valid); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ser_valid !== 1'b0 || ser_last !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL midrst_async got valid=%b last=%b busy=%b want 0 0 0", ser_valid, ser_last, busy);
    end
    n_cmp++; if (mux_sel !== 4'd0 || mux_in !== 16'h0000) begin n_err++; $display("FAIL midrst_regs got sel=%0d in=%h want 0 0000", mux_sel, mux_in); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 16'h0002; in_len = 4'd1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (mux_sel !== 4'd0 || ser_data !== 1'b0 || ser_last !== 1'b0) begin
      n_err++; $display("FAIL midrst_restart0 got sel=%0d data=%b last=%b want 0 0 0", mux_sel, ser_data, ser_last);
    end
    @(negedge clk);
    #1;
    n_cmp++; if (mux_sel !== 4'd1 || ser_data !== 1'b1 || ser_last !== 1'b1) begin
      n_err++; $display("FAIL midrst_restart1 got sel=%0d data=%b last=%b want 1 1 1", mux_sel, ser_data, ser_last);
    end
    @(negedge clk);
    check_idle("midrst");
  endtask

  task automatic test_msb_first();
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h8001; in_len = 4'd15; ser_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_cmp++; if (mux_sel !== 4'(15 - i)) begin n_err++; $display("FAIL msb_sel beat %0d got %0d want %0d", i, mux_sel, 15 - i); end
      n_cmp++; if (ser_data !== (i == 0 || i == 15)) begin n_err++; $display("FAIL msb_data beat %0d got %b want %b", i, ser_data, (i == 0 || i == 15)); end
      n_cmp++; if (ser_last !== (i == 15)) begin n_err++; $display("FAIL msb_last beat %0d got %b want %b", i, ser_last, (i == 15)); end
    end
    @(negedge clk);
    check_idle("msb");
  endtask

  initial begin
    test_reset();
`ifdef MUX_SERIALIZER_MSB_FIRST_EN
    test_msb_first();
`else
    test_lsb_full();
    test_single_bit();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
